// File: rtl/cpu_branch_trace_buffer.sv
// rtl/cpu_branch_trace_buffer.sv - control-flow discontinuity tracer with record FIFO
module cpu_branch_trace_buffer #(
  parameter int PC_W   = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                       clk_i,
  input  logic                       reset_n,
  input  logic                       en_i,
  input  logic                       clear_i,
  input  logic [PC_W-1:0]            pc_i,
  input  logic [DATA_W-1:0]          rd_val_i,
  output logic                       trace_v_o,
  input  logic                       trace_ready_i,
  output logic [PC_W-1:0]            trace_from_o,
  output logic [PC_W-1:0]            trace_to_o,
  output logic [DATA_W-1:0]          trace_rd_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic [15:0]                event_cnt_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {IDLE, TRACK} state_e;

  state_e              state_q;
  logic [PC_W-1:0]     pc_q;
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q;
  logic [15:0]         event_cnt_q;

  logic [PC_W-1:0]     mem_from [DEPTH];
  logic [PC_W-1:0]     mem_to   [DEPTH];
  logic [DATA_W-1:0]   mem_rd   [DEPTH];

  logic [PC_W-1:0]     pc_seq;
  logic                event_w, full_w, pop_w, push_w, drop_w;

  // Sequential successor wraps modulo 2^PC_W, so top-of-range to zero is not an event.
  assign pc_seq  = pc_q + 1'b1;
  assign event_w = (state_q == TRACK) && en_i && (pc_i != pc_q) && (pc_i != pc_seq);
  assign full_w  = (count_q == FULL_CNT);
  assign pop_w   = (count_q != '0) && trace_ready_i;
  assign push_w  = event_w && (!full_w || pop_w);
  assign drop_w  = event_w && full_w && !pop_w;

  always_comb begin
    count_d = count_q;
    if (push_w && !pop_w) begin
      count_d = count_q + 1'b1;
    end else if (pop_w && !push_w) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      event_cnt_q <= '0;
    end else if (clear_i) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      event_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (en_i) begin
            state_q <= TRACK;
            pc_q    <= pc_i;
          end
        end
        TRACK: begin
          if (!en_i) begin
            state_q <= IDLE;
          end else begin
            pc_q <= pc_i;
          end
        end
        default: state_q <= IDLE;
      endcase
      if (push_w) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop_w) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      if (drop_w) begin
        overflow_q <= 1'b1;
      end
      if (event_w && (event_cnt_q != 16'hFFFF)) begin
        event_cnt_q <= event_cnt_q + 16'd1;
      end
    end
  end

  // Record storage is deliberately left unreset; validity comes from count_q.
  always_ff @(posedge clk_i) begin
    if (push_w && !clear_i) begin
      mem_from[wr_ptr_q] <= pc_q;
      mem_to[wr_ptr_q]   <= pc_i;
      mem_rd[wr_ptr_q]   <= rd_val_i;
    end
  end

  assign trace_v_o    = (count_q != '0);
  assign trace_from_o = trace_v_o ? mem_from[rd_ptr_q] : '0;
  assign trace_to_o   = trace_v_o ? mem_to[rd_ptr_q]   : '0;
  assign trace_rd_o   = trace_v_o ? mem_rd[rd_ptr_q]   : '0;
  assign count_o      = count_q;
  assign overflow_o   = overflow_q;
  assign event_cnt_o  = event_cnt_q;

endmodule

// File: tb/tb_cpu_branch_trace_buffer.sv
// tb/tb_cpu_branch_trace_buffer.sv - directed self-checking bench for cpu_branch_trace_buffer
module tb_cpu_branch_trace_buffer;

  logic        clk_i = 1'b0;
  logic        reset_n;
  logic        en_i;
  logic        clear_i;
  logic [15:0] pc_i;
  logic [15:0] rd_val_i;
  logic        trace_v_o;
  logic        trace_ready_i;
  logic [15:0] trace_from_o;
  logic [15:0] trace_to_o;
  logic [15:0] trace_rd_o;
  logic [4:0]  count_o;
  logic        overflow_o;
  logic [15:0] event_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_branch_trace_buffer #(.PC_W(16), .DATA_W(16), .DEPTH(16)) dut (
    .clk_i         (clk_i),
    .reset_n       (reset_n),
    .en_i          (en_i),
    .clear_i       (clear_i),
    .pc_i          (pc_i),
    .rd_val_i      (rd_val_i),
    .trace_v_o     (trace_v_o),
    .trace_ready_i (trace_ready_i),
    .trace_from_o  (trace_from_o),
    .trace_to_o    (trace_to_o),
    .trace_rd_o    (trace_rd_o),
    .count_o       (count_o),
    .overflow_o    (overflow_o),
    .event_cnt_o   (event_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then settle just past the rising edge.
  task automatic cyc(input logic en, input logic [15:0] pc, input logic [15:0] rd,
                     input logic rdy, input logic clr);
    en_i = en; pc_i = pc; rd_val_i = rd; trace_ready_i = rdy; clear_i = clr;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; en_i = 1'b0; clear_i = 1'b0; pc_i = '0; rd_val_i = '0; trace_ready_i = 1'b0;
    #1;
    chk("reset_v", trace_v_o, 0);
    chk("reset_count", count_o, 0);
    chk("reset_from", trace_from_o, 0);
    @(posedge clk_i); #1;
    reset_n = 1'b1;

    for (int i = 0; i < 6; i++) cyc(1, 16'(i), 0, 0, 0);
    chk("seq_count", count_o, 0);
    chk("seq_evcnt", event_cnt_o, 0);
    chk("seq_v", trace_v_o, 0);

    cyc(0, 0, 0, 0, 0);
    cyc(1, 4, 0, 0, 0);
    cyc(1, 5, 0, 0, 0);
    chk("prejump_v", trace_v_o, 0);
    cyc(1, 35, 16'h0007, 0, 0);
    chk("jump_v", trace_v_o, 1);
    chk("jump_from", trace_from_o, 5);
    chk("jump_to", trace_to_o, 35);
    chk("jump_rd", trace_rd_o, 16'h0007);
    cyc(1, 36, 0, 0, 0);
    chk("jump_count", count_o, 1);
    cyc(1, 37, 0, 1, 0);
    chk("pop_count", count_o, 0);
    chk("pop_v", trace_v_o, 0);
    chk("pop_to_zero", trace_to_o, 0);
    chk("pop_evcnt", event_cnt_o, 1);

    cyc(0, 0, 0, 0, 1);
    chk("clear_evcnt", event_cnt_o, 0);
    cyc(1, 10, 0, 0, 0);
    cyc(1, 10, 0, 0, 0);
    cyc(1, 11, 0, 0, 0);
    cyc(0, 11, 0, 0, 0);
    cyc(1, 16'hFFFE, 0, 0, 0);
    cyc(1, 16'hFFFF, 0, 0, 0);
    cyc(1, 16'h0000, 0, 0, 0);
    chk("stallwrap_count", count_o, 0);
    chk("stallwrap_evcnt", event_cnt_o, 0);

    cyc(0, 0, 0, 0, 1);
    cyc(1, 46, 0, 0, 0);
    for (int i = 0; i < 17; i++) cyc(1, (i % 2 == 0) ? 16'd60 : 16'd46, 16'(i), 0, 0);
    chk("ovf_count", count_o, 16);
    chk("ovf_flag", overflow_o, 1);
    chk("ovf_evcnt", event_cnt_o, 17);
    chk("ovf_head_from", trace_from_o, 46);
    chk("ovf_head_to", trace_to_o, 60);
    chk("ovf_head_rd", trace_rd_o, 0);

    cyc(0, 0, 0, 0, 1);
    cyc(1, 46, 0, 0, 0);
    for (int i = 0; i < 16; i++) cyc(1, (i % 2 == 0) ? 16'd60 : 16'd46, 16'(i), 0, 0);
    chk("full_count", count_o, 16);
    chk("full_noovf", overflow_o, 0);
    cyc(1, 60, 16, 1, 0);
    chk("fullpp_count", count_o, 16);
    chk("fullpp_ovf", overflow_o, 0);
    chk("fullpp_evcnt", event_cnt_o, 17);
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("order_from_%0d", k), trace_from_o, (k % 2 == 0) ? 46 : 60);
      chk($sformatf("order_to_%0d", k), trace_to_o, (k % 2 == 0) ? 60 : 46);
      chk($sformatf("order_rd_%0d", k), trace_rd_o, k);
      cyc(0, 0, 0, 1, 0);
    end
    chk("drain_count", count_o, 0);
    chk("drain_v", trace_v_o, 0);

    cyc(0, 0, 0, 0, 1);
    cyc(1, 100, 0, 0, 0);
    cyc(1, 200, 1, 0, 0);
    cyc(1, 300, 2, 0, 0);
    cyc(1, 400, 3, 0, 0);
    chk("pre_rst_count", count_o, 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_v", trace_v_o, 0);
    chk("async_rst_count", count_o, 0);
    chk("async_rst_from", trace_from_o, 0);
    chk("async_rst_rd", trace_rd_o, 0);
    chk("async_rst_evcnt", event_cnt_o, 0);
    #1;
    reset_n = 1'b1;
    cyc(1, 999, 0, 0, 0);
    chk("post_rst_count", count_o, 0);
    chk("post_rst_evcnt", event_cnt_o, 0);
    cyc(1, 5000, 0, 0, 1);
    chk("clr_event_count", count_o, 0);
    chk("clr_event_evcnt", event_cnt_o, 0);
    cyc(1, 5001, 0, 0, 0);
    cyc(1, 7000, 0, 0, 0);
    chk("after_clr_count", count_o, 1);
    chk("after_clr_from", trace_from_o, 5001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_branch_trace_buffer.md
# cpu_branch_trace_buffer

Debug trace unit directly downstream of `cpu_pipeline_aes`. Samples the CPU's `pc_o` and `Rd_val` every cycle and detects control-flow discontinuities such as branches, calls (BL) and returns. Each discontinuity is logged as a {from_pc, to_pc, rd_val} record in a small FIFO that a host or bench drains through a valid/ready port. Jump/return sequences can then be checked in hardware or silicon debug without cycle-counting the PC.

## Interface
Parameters:
- `PC_W`, 16, PC width; matches CPU `pc_o`.
- `DATA_W`, 16, width of the sampled `Rd_val`.
- `DEPTH`, 16, FIFO entries; must be a power of 2 and at least 2.

Ports:
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  trace enable.
- `clear_i`  in  1  synchronous clear of FIFO, counters, overflow flag and PC history.
- `pc_i`  in  PC_W  CPU `pc_o`.
- `rd_val_i`  in  DATA_W  CPU `Rd_val`.
- `trace_v_o`  out  1  FIFO head valid.
- `trace_ready_i`  in  1  consumer accepts the head entry.
- `trace_from_o`  out  PC_W  PC before the discontinuity.
- `trace_to_o`  out  PC_W  PC after the discontinuity.
- `trace_rd_o`  out  DATA_W  `rd_val_i` at the event cycle.
- `count_o`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow_o`  out  1  sticky; set when an event is dropped because the FIFO is full.
- `event_cnt_o`  out  16  total events detected, including dropped ones; saturates at 0xFFFF.

## Operation
- **Tracker FSM states:**
  - IDLE: no valid previous PC.
  - TRACK: `pc_q` holds the last sampled PC.
- **FSM transitions:**
  - IDLE→TRACK on `en_i`=1. Captures `pc_q`<=`pc_i`; no event is generated.
  - TRACK→IDLE on `en_i`=0 or `clear_i`=1.
  - In TRACK, `pc_q`<=`pc_i` every cycle.
- **Event condition (TRACK and `en_i`):** `pc_i` != `pc_q` and `pc_i` != (`pc_q`+1) mod 2^PC_W.
  - A stall (unchanged PC) is not an event.
  - Wrap from 0xFFFF to 0x0000 is sequential, not an event.
- **Event push:**
  - Pushes {`pc_q`, `pc_i`, `rd_val_i`} if not full.
  - If full and no pop in the same cycle, the event is dropped and `overflow_o`<=1.
  - `event_cnt_o` increments on every event, saturating.
- **Pop:** occurs when `trace_v_o` && `trace_ready_i`. `trace_v_o` = (`count_o` != 0).
- **Simultaneous push and pop:**
  - Both take effect and `count_o` is unchanged.
  - When full, the push is accepted and no overflow is flagged.
  - When empty, only the push takes effect; there is no fall-through.
- **`clear_i` priority:** `clear_i` overrides push, pop and event counting. It empties the FIFO, zeroes `overflow_o` and `event_cnt_o`, and sets the FSM to IDLE.
- **Data outputs when idle:** `trace_from_o`, `trace_to_o` and `trace_rd_o` drive 0 when `trace_v_o`=0. FIFO storage itself is not reset.
- **Pointer width:** read and write pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are derived from `count_o`.

## Timing
- **Reset values:** on `reset_n` low, all outputs are 0 immediately (asynchronous): `trace_v_o`, data outputs, `count_o`, `overflow_o`, `event_cnt_o`. The FSM enters IDLE.
- **Reset mid-operation:** queued entries are lost.
- **Event detection:** combinational on `pc_i` vs `pc_q` before the edge; the push is committed at that edge.
- **Push-to-visible latency:** 1 cycle. An event at edge N gives `trace_v_o`=1 after edge N when previously empty.
- **Consecutive events:** back-to-back discontinuities on consecutive cycles each produce an entry. Example: PC 5→35→60 gives {5,35} and {35,60}.
- **Pop timing:** `count_o` and the head entry update at the edge where the pop occurs. The next entry is presented in the same cycle after that edge.
- **Re-enable:** after `en_i` deasserts and reasserts, the first cycle back is IDLE→TRACK with no event, even if the PC jumped while disabled.

## Test plan
- Reset, then `en_i`=1 with PC 0,1,2,3,4,5 → `count_o`=0, `event_cnt_o`=0, `trace_v_o`=0.
- PC 4,5,35,36 with `rd_val_i`=0x0007 at the 35 cycle → one entry {from 5, to 35, rd 0x0007}; `trace_v_o`=1 one cycle after the jump edge; pop with `trace_ready_i`=1 → `count_o`=0.
- PC 10,10,11 (stall) and 0xFFFE,0xFFFF,0x0000 (wrap) → no entries; `event_cnt_o`=0.
- 17 alternating jumps (PC toggling 60↔46) with `trace_ready_i`=0 → `count_o`=16, `overflow_o`=1, `event_cnt_o`=17; the first entry is intact.
- At full, hold `trace_ready_i`=1 on an event cycle → `count_o` stays 16 and `overflow_o` stays 0; the FIFO order is verified over 16 pops.
- `reset_n` driven low mid-cycle with 3 entries queued → all outputs 0 before the next edge; after release, the first PC causes no event. A `clear_i` pulse with a same-cycle event → `count_o`=0 and `event_cnt_o`=0.
